// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : reg_scoreboard
//  Description : Register-write scoreboard for the pipelined MIPS core.
//                Tracks outstanding writes with a saturating counter per
//                register and raises a stall on RAW hazards, or when the
//                destination counter is already full.
//  Revision    : 1.0  initial release
// ============================================================================
module reg_scoreboard #(
    parameter int ADDR_W   = 5,
    parameter int NREG     = 32,
    parameter int CNT_W    = 2,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              iss_valid,
    output logic              iss_ready,
    input  logic [ADDR_W-1:0] iss_dst,
    input  logic              iss_dst_we,
    input  logic [ADDR_W-1:0] iss_src_a,
    input  logic [ADDR_W-1:0] iss_src_b,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_dst,
    output logic              stall,
    output logic [NREG-1:0]   busy_vec,
    output logic [NREG-1:0]   dst_onehot,
    output logic              err_underflow
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // One-hot decode. Register 0 is hard-wired to zero on MIPS, so when
    // ZERO_REG is set it is masked out of every decode and can never be
    // tracked, busy or cause a stall.
    function automatic logic [NREG-1:0] f_dec(input logic [ADDR_W-1:0] x);
        logic [NREG-1:0] v;
        v    = '0;
        v[x] = 1'b1;
        if (ZERO_REG != 0) begin
            v[0] = 1'b0;
        end
        return v;
    endfunction

    logic [CNT_W-1:0] r_cnt [NREG];
    logic [NREG-1:0]  r_dst_onehot;
    logic             r_err_underflow;

    logic [NREG-1:0]  w_dec_dst;
    logic [NREG-1:0]  w_dec_src_a;
    logic [NREG-1:0]  w_dec_src_b;
    logic [NREG-1:0]  w_dec_wb;
    logic [NREG-1:0]  w_busy;
    logic [NREG-1:0]  w_full;
    logic [NREG-1:0]  w_inc;
    logic [NREG-1:0]  w_retire;
    logic             w_hazard;
    logic             w_stall;
    logic             w_acc;
    logic             w_underflow;

    assign w_dec_dst   = f_dec(iss_dst);
    assign w_dec_src_a = f_dec(iss_src_a);
    assign w_dec_src_b = f_dec(iss_src_b);
    assign w_dec_wb    = f_dec(wb_dst);

    // Per-register status flags derived from the registered counts only.
    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
            assign w_busy[gi] = (r_cnt[gi] != '0);
            assign w_full[gi] = (r_cnt[gi] == c_CNT_MAX);
        end
    endgenerate

    // Hazard check: pending source operand, or destination counter saturated.
    // No writeback bypass, so a retiring write still stalls this cycle.
    always_comb begin
        w_hazard = 1'b0;
        if (|(w_busy & w_dec_src_a)) begin
            w_hazard = 1'b1;
        end
        if (|(w_busy & w_dec_src_b)) begin
            w_hazard = 1'b1;
        end
        if (iss_dst_we && |(w_full & w_dec_dst)) begin
            w_hazard = 1'b1;
        end
    end

    assign w_stall  = iss_valid & w_hazard;
    assign w_acc    = iss_valid & ~w_stall;

    assign w_inc    = {NREG{w_acc & iss_dst_we}} & w_dec_dst;
    assign w_retire = {NREG{wb_valid}} & w_dec_wb;

    // A retire that is not cancelled by a same-cycle issue hitting an idle
    // register is a bookkeeping error upstream.
    assign w_underflow = |(w_retire & ~w_inc & ~w_busy);

    // Outstanding-write counters; flush wins over any same-cycle issue or wb.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_cnt[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < NREG; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (w_inc[i] && !w_retire[i]) begin
                    r_cnt[i] <= r_cnt[i] + c_CNT_ONE;
                end else if (w_retire[i] && !w_inc[i] && w_busy[i]) begin
                    r_cnt[i] <= r_cnt[i] - c_CNT_ONE;
                end
            end
        end
    end

    // Last accepted destination decode, held until the next write-issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dst_onehot <= '0;
        end else if (flush) begin
            r_dst_onehot <= '0;
        end else if (w_acc && iss_dst_we) begin
            r_dst_onehot <= w_dec_dst;
        end
    end

    // Single-cycle underflow flag, re-evaluated every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_underflow <= 1'b0;
        end else if (flush) begin
            r_err_underflow <= 1'b0;
        end else begin
            r_err_underflow <= w_underflow;
        end
    end

    assign stall         = w_stall;
    assign iss_ready     = ~w_stall;
    assign busy_vec      = w_busy;
    assign dst_onehot    = r_dst_onehot;
    assign err_underflow = r_err_underflow;

endmodule
`default_nettype wire

// File: tb/tb_reg_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_scoreboard
//  Description : Directed, table-driven self-checking bench for reg_scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_reg_scoreboard;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        iss_valid;
    logic        iss_ready;
    logic [4:0]  iss_dst;
    logic        iss_dst_we;
    logic [4:0]  iss_src_a;
    logic [4:0]  iss_src_b;
    logic        wb_valid;
    logic [4:0]  wb_dst;
    logic        stall;
    logic [31:0] busy_vec;
    logic [31:0] dst_onehot;
    logic        err_underflow;

    int n_checks;
    int n_errors;

    reg_scoreboard #(
        .ADDR_W   (5),
        .NREG     (32),
        .CNT_W    (2),
        .ZERO_REG (1)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .iss_valid     (iss_valid),
        .iss_ready     (iss_ready),
        .iss_dst       (iss_dst),
        .iss_dst_we    (iss_dst_we),
        .iss_src_a     (iss_src_a),
        .iss_src_b     (iss_src_b),
        .wb_valid      (wb_valid),
        .wb_dst        (wb_dst),
        .stall         (stall),
        .busy_vec      (busy_vec),
        .dst_onehot    (dst_onehot),
        .err_underflow (err_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        fl;
        logic        iv;
        logic [4:0]  dst;
        logic        we;
        logic [4:0]  sa;
        logic [4:0]  sb;
        logic        wv;
        logic [4:0]  wd;
        logic        e_stall;
        logic [31:0] e_busy;
        logic [31:0] e_oh;
        logic        e_err;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic fl, input logic iv, input logic [4:0] dst,
                                input logic we, input logic [4:0] sa, input logic [4:0] sb,
                                input logic wv, input logic [4:0] wd, input logic e_stall,
                                input logic [31:0] e_busy, input logic [31:0] e_oh,
                                input logic e_err);
        vec_t v;
        v.fl = fl; v.iv = iv; v.dst = dst; v.we = we; v.sa = sa; v.sb = sb;
        v.wv = wv; v.wd = wd; v.e_stall = e_stall; v.e_busy = e_busy;
        v.e_oh = e_oh; v.e_err = e_err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        flush = 1'b0; iss_valid = 1'b0; iss_dst = '0; iss_dst_we = 1'b0;
        iss_src_a = '0; iss_src_b = '0; wb_valid = 1'b0; wb_dst = '0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        drive_idle();

        //         fl iv dst we sa sb wv wd | stall busy          onehot        err
        vecs[0]  = mk(0, 1, 5, 1, 0, 0, 0, 0,  0, 32'h0000_0020, 32'h0000_0020, 0); // issue r5
        vecs[1]  = mk(0, 1, 1, 1, 0, 5, 0, 0,  1, 32'h0000_0020, 32'h0000_0020, 0); // src_b=r5 stalls
        vecs[2]  = mk(0, 1, 1, 1, 5, 0, 1, 5,  1, 32'h0000_0000, 32'h0000_0020, 0); // no wb bypass
        vecs[3]  = mk(0, 1, 1, 1, 5, 0, 0, 0,  0, 32'h0000_0002, 32'h0000_0002, 0); // stall dropped
        vecs[4]  = mk(0, 1, 7, 1, 0, 0, 0, 0,  0, 32'h0000_0082, 32'h0000_0080, 0); // r7 cnt 1
        vecs[5]  = mk(0, 1, 7, 1, 0, 0, 0, 0,  0, 32'h0000_0082, 32'h0000_0080, 0); // r7 cnt 2
        vecs[6]  = mk(0, 1, 7, 1, 0, 0, 0, 0,  0, 32'h0000_0082, 32'h0000_0080, 0); // r7 cnt 3
        vecs[7]  = mk(0, 1, 7, 1, 0, 0, 0, 0,  1, 32'h0000_0082, 32'h0000_0080, 0); // full -> stall
        vecs[8]  = mk(0, 1, 7, 1, 0, 0, 1, 7,  1, 32'h0000_0082, 32'h0000_0080, 0); // wb r7 -> cnt 2
        vecs[9]  = mk(0, 1, 7, 1, 0, 0, 0, 0,  0, 32'h0000_0082, 32'h0000_0080, 0); // 4th accepted
        vecs[10] = mk(0, 1, 9, 1, 0, 0, 0, 0,  0, 32'h0000_0282, 32'h0000_0200, 0); // r9 cnt 1
        vecs[11] = mk(0, 1, 9, 1, 0, 0, 1, 9,  0, 32'h0000_0282, 32'h0000_0200, 0); // inc&dec hold
        vecs[12] = mk(0, 0, 0, 0, 0, 0, 1, 12, 0, 32'h0000_0282, 32'h0000_0200, 1); // underflow
        vecs[13] = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 32'h0000_0282, 32'h0000_0200, 0); // pulse ends
        vecs[14] = mk(0, 1, 0, 1, 0, 0, 0, 0,  0, 32'h0000_0282, 32'h0000_0000, 0); // dst r0 masked
        vecs[15] = mk(0, 1, 3, 0, 0, 0, 0, 0,  0, 32'h0000_0282, 32'h0000_0000, 0); // src r0, no we
        vecs[16] = mk(0, 1, 4, 1, 0, 0, 0, 0,  0, 32'h0000_0292, 32'h0000_0010, 0); // r4 cnt 1
        vecs[17] = mk(0, 0, 0, 0, 0, 0, 1, 0,  0, 32'h0000_0292, 32'h0000_0010, 0); // wb r0 ignored
        vecs[18] = mk(1, 1, 6, 1, 0, 0, 1, 12, 0, 32'h0000_0000, 32'h0000_0000, 0); // flush wins
        vecs[19] = mk(0, 1, 2, 1, 5, 7, 0, 0,  0, 32'h0000_0004, 32'h0000_0004, 0); // clean after

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset busy_vec",   busy_vec, 32'h0);
        chk("reset dst_onehot", dst_onehot, 32'h0);
        chk("reset err",        {31'b0, err_underflow}, 32'h0);
        chk("reset iss_ready",  {31'b0, iss_ready}, 32'h1);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            flush     = vecs[i].fl;
            iss_valid = vecs[i].iv;
            iss_dst   = vecs[i].dst;
            iss_dst_we = vecs[i].we;
            iss_src_a = vecs[i].sa;
            iss_src_b = vecs[i].sb;
            wb_valid  = vecs[i].wv;
            wb_dst    = vecs[i].wd;
            #1;
            chk($sformatf("v%0d stall", i),     {31'b0, stall}, {31'b0, vecs[i].e_stall});
            chk($sformatf("v%0d iss_ready", i), {31'b0, iss_ready}, {31'b0, ~vecs[i].e_stall});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d busy_vec", i),   busy_vec, vecs[i].e_busy);
            chk($sformatf("v%0d dst_onehot", i), dst_onehot, vecs[i].e_oh);
            chk($sformatf("v%0d err", i),        {31'b0, err_underflow}, {31'b0, vecs[i].e_err});
        end

        // Async reset in the middle of a stalled cycle clears everything at once.
        @(negedge clk);
        drive_idle();
        iss_valid = 1'b1; iss_dst = 5'd8; iss_dst_we = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iss_dst = 5'd10; iss_src_a = 5'd8;
        #1;
        chk("pre-reset stall",    {31'b0, stall}, 32'h1);
        chk("pre-reset busy_vec", busy_vec, 32'h0000_0104);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async reset busy_vec",   busy_vec, 32'h0);
        chk("async reset dst_onehot", dst_onehot, 32'h0);
        chk("async reset stall",      {31'b0, stall}, 32'h0);
        @(negedge clk);
        drive_idle();
        rst_n = 1'b1;
        #1;
        chk("post-reset iss_ready", {31'b0, iss_ready}, 32'h1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
